// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit limits and a nibble validity check.
package bcd_pkg;

  localparam int BCD_WIDTH = 4;

  typedef logic [BCD_WIDTH-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // True when the nibble holds a legal decimal digit (0..9).
  function automatic logic bcd_valid(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Combinational single-digit BCD decrement with borrow chaining.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       borrow_in,
  output bcd_digit_t d_next,
  output logic       borrow_out
);

  // A digit at zero wraps to nine and passes the borrow to the next digit up.
  always_comb begin
    d_next     = d;
    borrow_out = borrow_in & (d == 4'd0);
    if (borrow_in) begin
      if (d == 4'd0) d_next = BCD_MAX;
      else           d_next = d - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with validated preset load, terminal-count
// pulse and optional auto-reload of the last valid preset.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   out,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  localparam int W = BCD_WIDTH * DIGITS;

  logic [W-1:0]    count_p0;
  logic [W-1:0]    reload_p0;
  logic            done_p0;
  logic            load_err_p0;

  logic [W-1:0]    dec_val;
  logic [DIGITS:0] borrow;
  logic            load_ok;
  logic            is_zero;
  logic            is_one;

  // Ripple-borrow chain; the borrow out of the top digit is set exactly when
  // every digit is zero, so it doubles as the zero detect.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_dec (
      .d          (count_p0[BCD_WIDTH*g +: BCD_WIDTH]),
      .borrow_in  (borrow[g]),
      .d_next     (dec_val[BCD_WIDTH*g +: BCD_WIDTH]),
      .borrow_out (borrow[g+1])
    );
  end

  assign is_zero = borrow[DIGITS];
  assign is_one  = (count_p0 == W'(1));

  // A preset is accepted only if every nibble is a legal decimal digit.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_val[BCD_WIDTH*i +: BCD_WIDTH])) load_ok = 1'b0;
    end
  end

  // Count register: reset > load > enable > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p0    <= '0;
      reload_p0   <= '0;
      done_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end else if (load) begin
      done_p0 <= 1'b0;
      if (load_ok) begin
        count_p0    <= load_val;
        reload_p0   <= load_val;
        load_err_p0 <= 1'b0;
      end else begin
        load_err_p0 <= 1'b1;
      end
    end else if (enable) begin
      if (!is_zero) begin
        count_p0 <= dec_val;
        done_p0  <= is_one;
      end else begin
        done_p0 <= 1'b0;
        if (AUTO_RELOAD && (reload_p0 != '0)) count_p0 <= reload_p0;
      end
    end else begin
      done_p0 <= 1'b0;
    end
  end

  assign out      = count_p0;
  assign zero     = is_zero;
  assign done     = done_p0;
  assign load_err = load_err_p0;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: three instances (2 digits hold-at-zero,
// 2 digits auto-reload, 3 digits) checked against a decimal scoreboard model.
module tb_bcd_down_counter;

  logic        clk = 1'b0;
  logic [2:0]  rst, en, ld;
  logic [7:0]  lv0, lv1;
  logic [11:0] lv2;
  logic [7:0]  out0, out1;
  logic [11:0] out2;
  logic [2:0]  zero, done, lerr;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .load(ld[0]), .load_val(lv0),
    .out(out0), .zero(zero[0]), .done(done[0]), .load_err(lerr[0]));

  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .load(ld[1]), .load_val(lv1),
    .out(out1), .zero(zero[1]), .done(done[1]), .load_err(lerr[1]));

  bcd_down_counter #(.DIGITS(3), .AUTO_RELOAD(1'b0)) dut2 (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .load(ld[2]), .load_val(lv2),
    .out(out2), .zero(zero[2]), .done(done[2]), .load_err(lerr[2]));

  typedef struct {
    int          idx;
    logic [31:0] out;
    logic        zero;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Model state, kept as plain decimal integers.
  int          m_cnt[3];
  int          m_rel[3];
  logic        m_done[3];
  logic        m_err[3];
  logic [31:0] v_in[3];

  function automatic int bcd2int(input logic [31:0] v, input int nd, output bit ok);
    int r;
    logic [3:0] nib;
    r  = 0;
    ok = 1'b1;
    for (int k = nd - 1; k >= 0; k--) begin
      nib = v[4*k +: 4];
      if (nib > 4'd9) ok = 1'b0;
      r = r * 10 + int'(nib);
    end
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic set_in(input int i, input logic r, input logic l,
                        input logic [31:0] v, input logic e);
    rst[i]  = r;
    ld[i]   = l;
    en[i]   = e;
    v_in[i] = v;
    case (i)
      0:       lv0 = v[7:0];
      1:       lv1 = v[7:0];
      default: lv2 = v[11:0];
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic check(input string tag, input int i,
                       input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    assert (act === exp_v) else begin
      errors++;
      $error("FAIL %s[%0d] got %h expected %h", tag, i, act, exp_v);
    end
  endtask

  // One clock: update the model from the applied inputs, push expectations,
  // let the DUTs take the edge, then pop and compare.
  task automatic step();
    exp_t e;
    logic [31:0] a_out;
    int nd, val;
    bit ok, ar;
    for (int i = 0; i < 3; i++) begin
      nd = (i == 2) ? 3 : 2;
      ar = (i == 1);
      if (rst[i]) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end else if (ld[i]) begin
        m_done[i] = 1'b0;
        val = bcd2int(v_in[i], nd, ok);
        if (ok) begin
          m_cnt[i] = val; m_rel[i] = val; m_err[i] = 1'b0;
        end else begin
          m_err[i] = 1'b1;
        end
      end else if (en[i]) begin
        if (m_cnt[i] != 0) begin
          m_cnt[i]  = m_cnt[i] - 1;
          m_done[i] = (m_cnt[i] == 0);
        end else begin
          m_done[i] = 1'b0;
          if (ar && m_rel[i] != 0) m_cnt[i] = m_rel[i];
        end
      end else begin
        m_done[i] = 1'b0;
      end
      e.idx  = i;
      e.out  = int2bcd(m_cnt[i]);
      e.zero = (m_cnt[i] == 0);
      e.done = m_done[i];
      e.err  = m_err[i];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.idx)
        0: begin a_out = {24'h0, out0}; check("out", 0, a_out, e.out); end
        1: begin a_out = {24'h0, out1}; check("out", 1, a_out, e.out); end
        default: begin a_out = {20'h0, out2}; check("out", 2, a_out, e.out); end
      endcase
      check("zero",     e.idx, {31'h0, zero[e.idx]}, {31'h0, e.zero});
      check("done",     e.idx, {31'h0, done[e.idx]}, {31'h0, e.done});
      check("load_err", e.idx, {31'h0, lerr[e.idx]}, {31'h0, e.err});
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
    end
    idle_all();

    // Reset held two cycles, then enable with nothing loaded.
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, 1'b0, 32'h0, 1'b0);
    run(2);
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 32'h0, 1'b1);
    run(3);
    idle_all();
    step();

    // Count 0x12 down to zero and hold there.
    set_in(0, 1'b0, 1'b1, 32'h12, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(16);

    // Invalid preset leaves the count, then a valid one clears the flag.
    set_in(0, 1'b0, 1'b1, 32'h1A, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 32'h0, 1'b0);
    run(2);
    set_in(0, 1'b0, 1'b1, 32'hA0, 1'b1);
    step();
    set_in(0, 1'b0, 1'b1, 32'h05, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 32'h0, 1'b0);
    run(2);

    // Load wins over enable.
    set_in(0, 1'b0, 1'b1, 32'h25, 1'b0);
    step();
    set_in(0, 1'b0, 1'b1, 32'h40, 1'b1);
    step();
    set_in(0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(3);

    // Loading zero gives no done pulse.
    set_in(0, 1'b0, 1'b1, 32'h00, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(3);
    idle_all();

    // Auto-reload: 03, 02, 01, 00, 03, ...
    set_in(1, 1'b0, 1'b1, 32'h03, 1'b0);
    step();
    set_in(1, 1'b0, 1'b0, 32'h0, 1'b1);
    run(10);
    set_in(1, 1'b0, 1'b0, 32'h0, 1'b0);
    run(2);
    set_in(1, 1'b0, 1'b0, 32'h0, 1'b1);
    run(3);

    // Reset mid-count at 0x17: no reload afterwards.
    set_in(1, 1'b0, 1'b1, 32'h19, 1'b0);
    step();
    set_in(1, 1'b0, 1'b0, 32'h0, 1'b1);
    run(2);
    set_in(1, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    set_in(1, 1'b0, 1'b0, 32'h0, 1'b1);
    run(6);
    idle_all();

    // Three digits: borrow ripples across two digits, then count out.
    set_in(2, 1'b0, 1'b1, 32'h100, 1'b0);
    step();
    set_in(2, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    run(99);
    run(2);
    idle_all();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
